// File: rtl/eth_tx_axis_arbiter.sv
// eth_tx_axis_arbiter: frame-granular round-robin tx AXI-stream arbiter with mid-frame stall watchdog
module eth_tx_axis_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int STALL_LIMIT = 16
) (
    input  logic                 tx_clk,
    input  logic                 tx_rst,
    input  logic [8*NUM_REQ-1:0] s_axis_tdata,
    input  logic [NUM_REQ-1:0]   s_axis_tvalid,
    output logic [NUM_REQ-1:0]   s_axis_tready,
    input  logic [NUM_REQ-1:0]   s_axis_tlast,
    input  logic [NUM_REQ-1:0]   s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 abort_pulse,
    output logic [15:0]          abort_count
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int SW = STALL_LIMIT > 0 ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIM  = SW'(STALL_LIMIT);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, PASS, ABORT, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      gidx_q, gidx_d, rr_ptr_q, rr_ptr_d, pick, cand, next_ptr;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SW-1:0]      stall_cnt_q, stall_cnt_d;
    logic [15:0]        abort_count_q, abort_count_d;
    logic               sel_valid, sel_last, sel_user;
    logic [7:0]         sel_data;

    assign sel_valid = s_axis_tvalid[gidx_q];
    assign sel_last  = s_axis_tlast[gidx_q];
    assign sel_user  = s_axis_tuser[gidx_q];
    assign sel_data  = s_axis_tdata[{gidx_q, 3'b000} +: 8];
    assign next_ptr  = (gidx_q == LAST) ? '0 : gidx_q + 1'b1;

    assign m_axis_tvalid = (state_q == PASS) ? sel_valid : (state_q == ABORT);
    assign m_axis_tdata  = (state_q == PASS) ? sel_data  : 8'h00;
    assign m_axis_tlast  = (state_q == PASS) ? sel_last  : (state_q == ABORT);
    assign m_axis_tuser  = (state_q == PASS) ? sel_user  : (state_q == ABORT);
    assign abort_pulse   = (state_q == ABORT) && m_axis_tready;
    assign grant         = grant_q;
    assign abort_count   = abort_count_q;

    // Scan downward so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        pick = rr_ptr_q;
        cand = rr_ptr_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (s_axis_tvalid[cand]) pick = cand;
        end
    end

    always_comb begin
        s_axis_tready = '0;
        if (state_q == PASS) s_axis_tready[gidx_q] = m_axis_tready;
        else if (state_q == DRAIN) s_axis_tready[gidx_q] = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        gidx_d        = gidx_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        stall_cnt_d   = '0;
        abort_count_d = abort_count_q;
        case (state_q)
            IDLE: if (|s_axis_tvalid) begin
                state_d = PASS;
                gidx_d  = pick;
                grant_d = NUM_REQ'(1) << pick;
            end
            PASS: begin
                stall_cnt_d = sel_valid ? '0 : (stall_cnt_q == LIM ? stall_cnt_q : stall_cnt_q + 1'b1);
                if (sel_valid && m_axis_tready && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                    grant_d  = '0;
                end else if (STALL_LIMIT != 0 && !sel_valid && stall_cnt_d == LIM) begin
                    state_d = ABORT;
                end
            end
            ABORT: if (m_axis_tready) begin
                state_d       = DRAIN;
                abort_count_d = (abort_count_q == 16'hFFFF) ? abort_count_q : abort_count_q + 16'd1;
            end
            DRAIN: if (sel_valid && sel_last) begin
                state_d  = IDLE;
                rr_ptr_d = next_ptr;
                grant_d  = '0;
            end
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q       <= IDLE;
            gidx_q        <= '0;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            stall_cnt_q   <= '0;
            abort_count_q <= '0;
        end else begin
            state_q       <= state_d;
            gidx_q        <= gidx_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            stall_cnt_q   <= stall_cnt_d;
            abort_count_q <= abort_count_d;
        end
    end
endmodule

// File: tb/tb_eth_tx_axis_arbiter.sv
// tb_eth_tx_axis_arbiter: frame-level scoreboard and round-robin model for the tx stream arbiter
module tb_eth_tx_axis_arbiter;
    logic tx_clk = 1'b0;
    logic tx_rst = 1'b1;
    always #5 tx_clk = ~tx_clk;

    logic [7:0]  sd [2];
    logic [1:0]  sv = '0, sl = '0, su = '0;
    logic [15:0] s_tdata;
    logic        mr = 1'b1;
    assign s_tdata = {sd[1], sd[0]};

    logic [1:0]  a_st, b_st, a_gr, b_gr;
    logic [7:0]  a_md, b_md;
    logic        a_mv, b_mv, a_ml, b_ml, a_mu, b_mu, a_ap, b_ap;
    logic [15:0] a_cnt, b_cnt;

    eth_tx_axis_arbiter #(.NUM_REQ(2), .STALL_LIMIT(16)) dut (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(sv),
        .s_axis_tready(a_st), .s_axis_tlast(sl), .s_axis_tuser(su), .m_axis_tdata(a_md),
        .m_axis_tvalid(a_mv), .m_axis_tready(mr), .m_axis_tlast(a_ml), .m_axis_tuser(a_mu),
        .grant(a_gr), .abort_pulse(a_ap), .abort_count(a_cnt));

    eth_tx_axis_arbiter #(.NUM_REQ(2), .STALL_LIMIT(0)) dut_nw (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(sv),
        .s_axis_tready(b_st), .s_axis_tlast(sl), .s_axis_tuser(su), .m_axis_tdata(b_md),
        .m_axis_tvalid(b_mv), .m_axis_tready(mr), .m_axis_tlast(b_ml), .m_axis_tuser(b_mu),
        .grant(b_gr), .abort_pulse(b_ap), .abort_count(b_cnt));

    bit sel_nw = 1'b0;
    logic [1:0]  st, gr;
    logic [7:0]  md;
    logic        mv, ml, mu, ap;
    logic [15:0] cnt;
    assign st  = sel_nw ? b_st  : a_st;
    assign gr  = sel_nw ? b_gr  : a_gr;
    assign md  = sel_nw ? b_md  : a_md;
    assign mv  = sel_nw ? b_mv  : a_mv;
    assign ml  = sel_nw ? b_ml  : a_ml;
    assign mu  = sel_nw ? b_mu  : a_mu;
    assign ap  = sel_nw ? b_ap  : a_ap;
    assign cnt = sel_nw ? b_cnt : a_cnt;

    int n_tests = 0, n_fail = 0;
    int rr, cur, exp_aborts, pulses, rdy_mode = 0;
    bit busy, pend, mon_en = 1'b0;
    logic [1:0] exp_grant;
    logic [9:0] exp0 [$], exp1 [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge tx_clk);
        #1;
    endtask

    initial forever begin
        tick;
        mr = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~mr : ($urandom_range(0, 3) != 0);
    end

    // Frame-level reference: ownership changes only between frames, next owner is first valid at/after rr.
    always @(negedge tx_clk) if (mon_en) begin
        int sz;
        logic [9:0] e;
        if (pend) begin
            check("arb_grant", gr, exp_grant);
            pend = 1'b0;
            busy = 1'b1;
        end else if (!busy) begin
            check("idle_out", {gr, mv}, 0);
            if (|sv) begin
                for (int k = 1; k >= 0; k--) if (sv[(rr + k) % 2]) cur = (rr + k) % 2;
                exp_grant = 2'(1 << cur);
                pend = 1'b1;
            end
        end
        if (mv && mr) begin
            sz = cur ? exp1.size() : exp0.size();
            check("beat_avail", sz > 0, 1);
            if (sz > 0) begin
                e = cur ? exp1.pop_front() : exp0.pop_front();
                check("beat", {gr, ml, mu, md}, {exp_grant, e});
            end
        end
        if (ap) pulses++;
    end

    task automatic reset_dut;
        mon_en = 1'b0;
        tx_rst = 1'b1;
        sv = '0; sl = '0; su = '0; sd[0] = '0; sd[1] = '0;
        tick; tick;
        @(negedge tx_clk);
        check("rst_grant", gr, 0);
        check("rst_mctl", {ml, mu, mv}, 0);
        check("rst_mdata", md, 0);
        check("rst_sready", st, 0);
        check("rst_cnt", cnt, 0);
        tick;
        tx_rst = 1'b0;
        rr = 0; busy = 1'b0; pend = 1'b0;
        exp0.delete(); exp1.delete();
        exp_aborts = 0; pulses = 0;
        mon_en = 1'b1;
    endtask

    task automatic send_frame(input int s, input int len, input int stall_at, input int stall_len, input bit seq);
        logic [7:0] bytes [$];
        logic usr;
        bit hs, aborted;
        int n, g;
        usr = seq ? 1'b0 : 1'($urandom_range(0, 1));
        aborted = stall_len >= 16 && !sel_nw && stall_at > 0 && stall_at < len;
        for (int i = 0; i < len; i++) begin
            bytes.push_back(seq ? 8'(i) : 8'($urandom));
            if (!aborted || i < stall_at) begin
                if (s == 0) exp0.push_back({i == len - 1, usr, bytes[i]});
                else exp1.push_back({i == len - 1, usr, bytes[i]});
            end
        end
        if (aborted) begin
            if (s == 0) exp0.push_back(10'h300);
            else exp1.push_back(10'h300);
        end
        for (int i = 0; i < len; i++) begin
            g = (i == stall_at && stall_len > 0) ? stall_len : seq ? 0 : $urandom_range(0, 2);
            if (g > 0) begin
                sv[s] = 1'b0;
                sl[s] = 1'b0;
                repeat (g) tick;
            end
            sd[s] = bytes[i]; sv[s] = 1'b1; sl[s] = (i == len - 1); su[s] = usr;
            n = 0;
            hs = 1'b0;
            while (!hs && n < 3000) begin
                @(negedge tx_clk);
                hs = st[s];
                tick;
                n++;
            end
            if (!hs) check("hs_timeout", n, 0);
        end
        sv[s] = 1'b0;
        sl[s] = 1'b0;
        busy = 1'b0;
        rr = (s + 1) % 2;
        if (aborted) exp_aborts++;
    endtask

    task automatic src_run(input int s, input int nfr);
        int len, at, sl_len, mode;
        for (int f = 0; f < nfr; f++) begin
            len = $urandom_range(2, 12);
            at = $urandom_range(1, len - 1);
            mode = $urandom_range(0, 3);
            sl_len = mode == 0 ? $urandom_range(16, 20) : mode == 1 ? $urandom_range(4, 15) : 0;
            send_frame(s, len, at, sl_len, 1'b0);
        end
    endtask

    task automatic end_scn(input string tag);
        repeat (3) tick;
        @(negedge tx_clk);
        check({tag, "_q0"}, exp0.size(), 0);
        check({tag, "_q1"}, exp1.size(), 0);
        check({tag, "_abort_cnt"}, cnt, exp_aborts);
        check({tag, "_pulses"}, pulses, exp_aborts);
        tick;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        reset_dut;
        send_frame(0, 64, 0, 0, 1'b1);
        tick; tick;
        fork
            send_frame(0, 4, 0, 0, 1'b1);
            send_frame(1, 4, 0, 0, 1'b1);
        join
        end_scn("single");
        fork
            repeat (4) send_frame(0, 4, 0, 0, 1'b1);
            repeat (4) send_frame(1, 4, 0, 0, 1'b1);
        join
        end_scn("fair");
        rdy_mode = 1;
        send_frame(0, 10, 0, 0, 1'b1);
        end_scn("bp");
        rdy_mode = 0;
        send_frame(1, 10, 6, 16, 1'b1);
        send_frame(0, 10, 6, 15, 1'b1);
        end_scn("stall");
        reset_dut;
        rdy_mode = 2;
        fork
            src_run(0, 12);
            src_run(1, 12);
        join
        end_scn("rand");
        rdy_mode = 0;
        sel_nw = 1'b1;
        reset_dut;
        send_frame(0, 8, 3, 1000, 1'b1);
        end_scn("nowd");
        sel_nw = 1'b0;
        reset_dut;
        send_frame(0, 2, 0, 0, 1'b1);
        tick;
        mon_en = 1'b0;
        sd[1] = 8'h00;
        sv[1] = 1'b1;
        tick;
        repeat (3) begin
            tick;
            sd[1] = sd[1] + 8'h01;
        end
        @(negedge tx_clk);
        check("pre_rst", {gr, mv, md}, {2'b10, 1'b1, 8'h03});
        tx_rst = 1'b1;
        tick;
        tx_rst = 1'b0;
        sv = 2'b11;
        sd[0] = 8'h55;
        @(negedge tx_clk);
        check("midrst_grant", gr, 0);
        check("midrst_mctl", {ml, mu, mv}, 0);
        check("midrst_mdata", md, 0);
        check("midrst_sready", st, 0);
        check("midrst_cnt", cnt, 0);
        tick;
        @(negedge tx_clk);
        check("rr_restart", gr, 2'b01);
        sv = '0;
        tick;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
